// File: rtl/spi_temp_reader_if.sv
// -----------------------------------------------------------------------------
// spi_temp_reader_if
// Bundles the SPI pins and the frame-result signals of spi_temp_reader.
//   start    : request one frame (sampled only while the reader is idle)
//   miso     : sensor serial data into the reader
//   sclk     : SPI clock, idles low
//   cs_n     : chip select, active low
//   mosi     : command serial data out of the reader
//   spi_data : last complete 24-bit frame, [23] = first bit received
//   new_data : one-cycle strobe when spi_data updates
//   busy     : frame in progress (start acceptance through the deselect gap)
// Modports: master = the reader itself, slave = whatever drives start/miso.
// -----------------------------------------------------------------------------
interface spi_temp_reader_if;
   logic        start;
   logic        miso;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic [23:0] spi_data;
   logic        new_data;
   logic        busy;

   modport master (
      input  start, miso,
      output sclk, cs_n, mosi, spi_data, new_data, busy
   );

   modport slave (
      output start, miso,
      input  sclk, cs_n, mosi, spi_data, new_data, busy
   );
endinterface

// File: rtl/spi_temp_reader.sv
// -----------------------------------------------------------------------------
// spi_temp_reader
// SPI master (mode 0, MSB first) reading one 24-bit frame from the temperature
// sensor and handing it to the BCD/display path as spi_data + new_data.
// CMD is shifted out on MOSI during the first 8 SCLK periods, zeros after.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset (aborts any frame in flight)
//   bus  : spi_temp_reader_if.master (start, miso, sclk, cs_n, mosi,
//          spi_data, new_data, busy)
//
// Parameters: CLK_DIV (clk cycles per SCLK half period, >= 1), CMD (command
// byte), POLL_PERIOD (clk cycles between automatic reads).
//
// Optional feature: define SPI_TEMP_READER_AUTO_POLL_EN to add a free-running
// poll counter that requests a frame every POLL_PERIOD cycles. Without it,
// frames start only from bus.start.
//
// Frame timeline (start accepted at edge k, D = CLK_DIV):
//   SETUP  D cycles with cs_n low, sclk low
//   SHIFT  24 bits x 2D cycles; sample on the sclk rise, advance mosi on fall
//   DONE   1 cycle, cs_n already high; spi_data/new_data registered at its end
//   GAP    D cycles of deselect time, then IDLE
// new_data is therefore high after edge k + 49*D + 1.
// -----------------------------------------------------------------------------
module spi_temp_reader #(
   parameter int unsigned CLK_DIV     = 4,
   parameter logic [7:0]  CMD         = 8'h00,
   parameter int unsigned POLL_PERIOD = 100000
) (
   input  logic              clk,
   input  logic              rst,
   spi_temp_reader_if.master bus
);

   localparam int unsigned   HW        = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

   if (CLK_DIV == 0 || POLL_PERIOD < 2) begin : g_bad_params
      $error("spi_temp_reader: CLK_DIV must be >= 1 and POLL_PERIOD >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_DONE,
      S_GAP
   } state_e;

   state_e        state_q,    state_d;
   logic [HW-1:0] half_q,     half_d;      // cycles within the current half period
   logic [4:0]    bit_q,      bit_d;       // 23..0, never wraps below 0
   logic [23:0]   shift_q,    shift_d;     // MISO capture, LSB in
   logic [7:0]    tx_q,       tx_d;        // remaining command bits, MSB = mosi
   logic          sclk_q,     sclk_d;
   logic          cs_n_q,     cs_n_d;
   logic          busy_q,     busy_d;
   logic          new_data_q, new_data_d;
   logic [23:0]   spi_data_q, spi_data_d;
   logic          start_eff;

`ifdef SPI_TEMP_READER_AUTO_POLL_EN
   localparam int unsigned PW = $clog2(POLL_PERIOD);

   logic [PW-1:0] poll_q;
   logic          poll_tc;

   assign poll_tc = (poll_q == PW'(POLL_PERIOD - 1));

   // Free-running; a terminal count that lands outside IDLE is simply lost.
   always_ff @(posedge clk) begin
      if (rst || poll_tc) poll_q <= '0;
      else                poll_q <= poll_q + 1'b1;
   end

   assign start_eff = bus.start | poll_tc;
`else
   assign start_eff = bus.start;
`endif

   // NOTE: every _d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      half_d     = half_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      spi_data_d = spi_data_q;
      new_data_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_eff) begin
               state_d = S_SETUP;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               tx_d    = CMD;
               half_d  = '0;
               bit_d   = 5'd23;
            end
         end

         S_SETUP: begin
            if (half_q == HALF_LAST) begin
               // First rising SCLK edge; bit 23 is already on MISO since cs_n fell.
               state_d = S_SHIFT;
               half_d  = '0;
               sclk_d  = 1'b1;
               shift_d = {shift_q[22:0], bus.miso};
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         S_SHIFT: begin
            if (half_q != HALF_LAST) begin
               half_d = half_q + 1'b1;
            end else begin
               half_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[6:0], 1'b0};
               end else if (bit_q == 5'd0) begin
                  state_d = S_DONE;
                  cs_n_d  = 1'b1;
                  tx_d    = '0;
               end else begin
                  bit_d   = bit_q - 5'd1;
                  sclk_d  = 1'b1;
                  shift_d = {shift_q[22:0], bus.miso};
               end
            end
         end

         S_DONE: begin
            spi_data_d = shift_q;
            new_data_d = 1'b1;
            state_d    = S_GAP;
         end

         S_GAP: begin
            if (half_q == HALF_LAST) begin
               state_d = S_IDLE;
               half_d  = '0;
               busy_d  = 1'b0;
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         half_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         new_data_q <= 1'b0;
         spi_data_q <= '0;
      end else begin
         state_q    <= state_d;
         half_q     <= half_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         new_data_q <= new_data_d;
         spi_data_q <= spi_data_d;
      end
   end

   assign bus.sclk     = sclk_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.mosi     = tx_q[7];
   assign bus.spi_data = spi_data_q;
   assign bus.new_data = new_data_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_temp_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_temp_reader
// Drives spi_temp_reader (CLK_DIV=2, CMD=8'hA5) against a mode-0 sensor model.
// Expected frames are queued when a start is issued; a monitor pops and
// compares them whenever new_data is seen.
// -----------------------------------------------------------------------------
module tb_spi_temp_reader;

   localparam int unsigned CLK_DIV = 2;
   localparam logic [7:0]  CMD     = 8'hA5;
   localparam int unsigned LAT     = 49 * CLK_DIV + 1;

   typedef struct {
      logic [23:0] data;
      logic [23:0] mosi_word;
   } exp_t;

   exp_t sb_q[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_temp_reader_if bus ();

   spi_temp_reader #(
      .CLK_DIV     (CLK_DIV),
      .CMD         (CMD),
      .POLL_PERIOD (300)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- sensor model (mode 0) ----------------
   logic [23:0] slave_data   = '0;
   logic [23:0] rx_word      = '0;
   int          s_idx        = 23;
   int          rises        = 0;
   int          mosi_idle_err = 0;
   logic        s_prev_sclk  = 1'b0;
   logic        s_prev_cs    = 1'b1;

   assign bus.miso = slave_data[s_idx[4:0]];

   initial begin
      forever begin
         @(negedge clk);
         if (s_prev_cs && !bus.cs_n) begin
            s_idx   = 23;
            rises   = 0;
            rx_word = '0;
         end else if (!bus.cs_n && s_prev_sclk && !bus.sclk && s_idx > 0) begin
            s_idx--;
         end
         if (!bus.cs_n && !s_prev_sclk && bus.sclk) begin
            rises++;
            rx_word = {rx_word[22:0], bus.mosi};
         end
         if (bus.cs_n === 1'b1 && bus.mosi !== 1'b0) mosi_idle_err++;
         s_prev_sclk = bus.sclk;
         s_prev_cs   = bus.cs_n;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int          nd_count   = 0;
   int          starts     = 0;
   int          t_start    = 0;
   int          t_nd       = 0;
   int          last_gap   = 0;
   int          glitch_err = 0;
   logic        m_prev_busy = 1'b0;
   logic        m_prev_nd   = 1'b0;
   logic        m_prev_cs   = 1'b1;
   logic        m_prev_rst  = 1'b1;
   logic [23:0] m_prev_data = '0;
   exp_t        e;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.busy && !m_prev_busy) begin
            t_start = cyc;
            starts++;
         end
         if (m_prev_cs && !bus.cs_n) last_gap = cyc - t_nd;
         if (!bus.new_data && !rst && !m_prev_rst && bus.spi_data !== m_prev_data) glitch_err++;
         if (bus.new_data) begin
            nd_count++;
            t_nd = cyc;
            check("new_data_single_cycle", 32'(m_prev_nd), 32'd0);
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_new_data: spi_data=0x%0h with no frame expected", bus.spi_data);
            end else begin
               e = sb_q.pop_front();
               check("spi_data",        32'(bus.spi_data), 32'(e.data));
               check("mosi_word",       32'(rx_word),      32'(e.mosi_word));
               check("sclk_rises",      rises,             24);
               check("latency",         cyc - t_start,     LAT);
               check("cs_n_high_at_nd", 32'(bus.cs_n),     32'd1);
            end
         end
         m_prev_busy = bus.busy;
         m_prev_nd   = bus.new_data;
         m_prev_cs   = bus.cs_n;
         m_prev_rst  = rst;
         m_prev_data = bus.spi_data;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_frame(input logic [23:0] data);
      sb_q.push_back('{data: data, mosi_word: {CMD, 16'h0000}});
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || bus.busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_in_time"}, 32'(n < budget), 32'd1);
   endtask

   int base;
   int base_starts;
   int n;

   initial begin
      bus.start = 1'b0;
      rst       = 1'b1;
      tick(3);
      check("reset_cs_n",     32'(bus.cs_n),     32'd1);
      check("reset_sclk",     32'(bus.sclk),     32'd0);
      check("reset_mosi",     32'(bus.mosi),     32'd0);
      check("reset_spi_data", 32'(bus.spi_data), 32'd0);
      check("reset_new_data", 32'(bus.new_data), 32'd0);
      check("reset_busy",     32'(bus.busy),     32'd0);
      rst = 1'b0;
      tick(2);

      // Single read with command byte.
      slave_data = 24'h006464;
      expect_frame(24'h006464);
      pulse_start();
      wait_idle("read", 300);
      check("spi_data_holds", 32'(bus.spi_data), 32'h006464);

      // Start pulsed mid-frame is ignored.
      base       = nd_count;
      slave_data = 24'hC3A517;
      expect_frame(24'hC3A517);
      pulse_start();
      tick(30);
      pulse_start();
      wait_idle("midframe", 300);
      tick(150);
      check("midframe_one_frame", nd_count - base, 1);

      // Start held high: two back-to-back frames.
      base        = nd_count;
      base_starts = starts;
      slave_data  = 24'h3C5A96;
      expect_frame(24'h3C5A96);
      expect_frame(24'h3C5A96);
      bus.start = 1'b1;
      n = 0;
      while (starts < base_starts + 2 && n < 400) begin
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      check("held_two_starts", starts - base_starts, 2);
      wait_idle("held", 300);
      check("back_to_back_gap", last_gap, CLK_DIV + 1);
      check("held_two_frames", nd_count - base, 2);

      // Reset during bit 10 aborts the frame.
      slave_data = 24'h004444;
      pulse_start();
      tick(1);
      n = 0;
      while (rises < 14 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reached_bit10", rises, 14);
      rst = 1'b1;
      tick(1);
      check("abort_cs_n",     32'(bus.cs_n),     32'd1);
      check("abort_sclk",     32'(bus.sclk),     32'd0);
      check("abort_spi_data", 32'(bus.spi_data), 32'd0);
      check("abort_busy",     32'(bus.busy),     32'd0);
      rst = 1'b0;
      base = nd_count;
      tick(150);
      check("abort_no_new_data", nd_count - base, 0);
      check("abort_data_zero",   32'(bus.spi_data), 32'd0);

      expect_frame(24'h004444);
      pulse_start();
      wait_idle("after_abort", 300);

      check("mosi_low_while_deselected", mosi_idle_err, 0);
      check("spi_data_stable",           glitch_err,    0);
      check("scoreboard_empty",          sb_q.size(),   0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
